// File: rtl/dmux_8way.sv
// Registered 1-to-8 demultiplexer. An enabled capture routes `in` to the channel
// chosen by `sel`, zeroes the other seven channels, and records `sel` and a valid flag.
module dmux_8way #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             valid,
  output logic [2:0]       sel_q
);

  logic [7:0][WIDTH-1:0] chan_d;
  logic [7:0][WIDTH-1:0] chan_q;
  logic [2:0]            sel_cap_d;
  logic [2:0]            sel_cap_q;
  logic                  valid_d;
  logic                  valid_q;
  logic [7:0]            chan_hot_s;

  // Full 3-to-8 decode; every code owns exactly one channel.
  function automatic logic [7:0] decode_sel(input logic [2:0] s);
    logic [7:0] hot;
    case (s)
      3'd0:    hot = 8'b0000_0001;
      3'd1:    hot = 8'b0000_0010;
      3'd2:    hot = 8'b0000_0100;
      3'd3:    hot = 8'b0000_1000;
      3'd4:    hot = 8'b0001_0000;
      3'd5:    hot = 8'b0010_0000;
      3'd6:    hot = 8'b0100_0000;
      3'd7:    hot = 8'b1000_0000;
      default: hot = 8'b0000_0000;
    endcase
    return hot;
  endfunction

  // Next-state: masked routing on capture, otherwise hold data and drop valid.
  always_comb begin
    chan_hot_s = decode_sel(sel);
    chan_d     = chan_q;
    sel_cap_d  = sel_cap_q;
    valid_d    = 1'b0;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        chan_d[i] = in & {WIDTH{chan_hot_s[i]}};
      end
      sel_cap_d = sel;
      valid_d   = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q    <= {(8*WIDTH){1'b0}};
      sel_cap_q <= 3'b000;
      valid_q   <= 1'b0;
    end else begin
      chan_q    <= chan_d;
      sel_cap_q <= sel_cap_d;
      valid_q   <= valid_d;
    end
  end

  assign a     = chan_q[0];
  assign b     = chan_q[1];
  assign c     = chan_q[2];
  assign d     = chan_q[3];
  assign e     = chan_q[4];
  assign f     = chan_q[5];
  assign g     = chan_q[6];
  assign h     = chan_q[7];
  assign valid = valid_q;
  assign sel_q = sel_cap_q;

endmodule

// File: tb/tb_dmux_8way.sv
// Bench for dmux_8way: an 8-bit and a 1-bit instance share stimulus and are
// compared each cycle against a channel-array model, plus literal spot checks.
module tb_dmux_8way;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] din = 8'h00;

  logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;
  logic       a1, b1, c1, d1, e1, f1, g1, h1;
  logic       valid8, valid1;
  logic [2:0] selq8, selq1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_ch [8];
  logic [2:0] exp_sel;
  logic       exp_valid;

  always #5 clk = ~clk;

  dmux_8way #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .sel(sel),
    .a(a8), .b(b8), .c(c8), .d(d8), .e(e8), .f(f8), .g(g8), .h(h8),
    .valid(valid8), .sel_q(selq8)
  );

  dmux_8way #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din[0]), .sel(sel),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .valid(valid1), .sel_q(selq1)
  );

  logic [7:0] o8 [8];
  logic       o1 [8];
  assign o8[0] = a8; assign o8[1] = b8; assign o8[2] = c8; assign o8[3] = d8;
  assign o8[4] = e8; assign o8[5] = f8; assign o8[6] = g8; assign o8[7] = h8;
  assign o1[0] = a1; assign o1[1] = b1; assign o1[2] = c1; assign o1[3] = d1;
  assign o1[4] = e1; assign o1[5] = f1; assign o1[6] = g1; assign o1[7] = h1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a captured word lands in channel[sel], everything else is zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) exp_ch[i] <= 8'h00;
      exp_sel   <= 3'd0;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= en;
      if (en) begin
        for (int i = 0; i < 8; i++) exp_ch[i] <= (i == int'(sel)) ? din : 8'h00;
        exp_sel <= sel;
      end
    end
  end

  // Compare both instances to the model on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w8_ch%0d", i), o8[i], exp_ch[i]);
      check($sformatf("w1_ch%0d", i), {7'd0, o1[i]}, {7'd0, exp_ch[i][0]});
    end
    check("w8_valid", {7'd0, valid8}, {7'd0, exp_valid});
    check("w1_valid", {7'd0, valid1}, {7'd0, exp_valid});
    check("w8_sel_q", {5'd0, selq8}, {5'd0, exp_sel});
    check("w1_sel_q", {5'd0, selq1}, {5'd0, exp_sel});
  end

  task automatic drive(input logic e_i, input logic [2:0] s_i, input logic [7:0] d_i);
    @(negedge clk);
    #1;
    en  = e_i;
    sel = s_i;
    din = d_i;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_a_w8", a8, 8'h00);
    check("reset_h_w8", h8, 8'h00);
    check("reset_valid", {7'd0, valid8}, 8'h00);
    check("reset_sel_q", {5'd0, selq8}, 8'h00);

    @(negedge clk);
    #1 rst_n = 1'b1;

    // Zero data across every code.
    for (int s = 0; s < 8; s++) drive(1'b1, 3'(s), 8'h00);
    // Single-bit sweep.
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s), 8'h01);
      if (s == 3) begin
        after_edge();
        check("sweep_d1", {7'd0, d1}, 8'h01);
        check("sweep_c1", {7'd0, c1}, 8'h00);
      end
    end

    drive(1'b1, 3'd6, 8'hA5);
    after_edge();
    check("a5_g", g8, 8'hA5);
    check("a5_a", a8, 8'h00);
    check("a5_h", h8, 8'h00);
    drive(1'b1, 3'd1, 8'h3C);
    drive(1'b1, 3'd7, 8'hFF);
    drive(1'b1, 3'd0, 8'h80);
    drive(1'b1, 3'd4, 8'h5B);

    // Hold while disabled.
    drive(1'b1, 3'd3, 8'h01);
    after_edge();
    check("hold_pre_d1", {7'd0, d1}, 8'h01);
    drive(1'b0, 3'd5, 8'h01);
    after_edge();
    check("hold_d1", {7'd0, d1}, 8'h01);
    check("hold_f1", {7'd0, f1}, 8'h00);
    check("hold_valid", {7'd0, valid1}, 8'h00);
    check("hold_sel_q", {5'd0, selq1}, 8'h03);
    drive(1'b0, 3'd2, 8'hEE);

    // Channel move a -> h on one edge.
    drive(1'b1, 3'd0, 8'h01);
    after_edge();
    check("move_pre_a", {7'd0, a1}, 8'h01);
    drive(1'b1, 3'd7, 8'h01);
    after_edge();
    check("move_a", {7'd0, a1}, 8'h00);
    check("move_h", {7'd0, h1}, 8'h01);

    // Mid-cycle reset with a capture pending.
    drive(1'b1, 3'd2, 8'hC3);
    after_edge();
    check("pre_rst_c", c8, 8'hC3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_c", c8, 8'h00);
    check("rst_valid", {7'd0, valid8}, 8'h00);
    check("rst_sel_q", {5'd0, selq8}, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 3'd5, 8'h69);
    after_edge();
    check("post_rst_f", f8, 8'h69);
    drive(1'b0, 3'd0, 8'h00);
    drive(1'b0, 3'd0, 8'h00);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
